// File: rtl/fdd_pkg.sv
// Shared floppy-emulation definitions: MFM cell timing, sync pattern, encoder.
package fdd_pkg;

  localparam int unsigned MFM_CELL_CLKS  = 56;
  localparam int unsigned MFM_PULSE_CLKS = 4;
  localparam logic [15:0] MFM_SYNC_A1    = 16'h4489;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun
  } mfm_state_e;

  typedef struct packed {
    logic       sync;
    logic [7:0] data;
  } mfm_byte_t;

  // MFM pattern for one byte, cell 0 in bit 15. Cell 2k is the clock for data bit 7-k,
  // cell 2k+1 is the data bit itself.
  function automatic logic [15:0] mfm_encode(input logic prev_d, input logic [7:0] data);
    logic [15:0] cells;
    logic        p;
    cells = '0;
    p     = prev_d;
    for (int k = 0; k < 8; k++) begin
      cells[15-2*k] = ~p & ~data[7-k];
      cells[14-2*k] = data[7-k];
      p             = data[7-k];
    end
    return cells;
  endfunction

endpackage

// File: rtl/mfm_cell_timer.sv
// MFM cell timer: counts clocks within a cell and cells within a byte, and
// flags cell end, byte end and whether the next cycle lies in the pulse window.
module mfm_cell_timer
  import fdd_pkg::*;
(
  input  logic fclk,
  input  logic rst_n,
  input  logic run,
  output logic cell_end,
  output logic byte_end,
  output logic pulse_next
);

  localparam logic [5:0] CNT_LAST  = 6'(MFM_CELL_CLKS - 1);
  localparam logic [5:0] PULSE_LEN = 6'(MFM_PULSE_CLKS);

  logic [5:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;

  assign cell_end = (cnt_q == CNT_LAST);
  assign byte_end = cell_end && (idx_q == 4'd15);

  // Counters advance only while running; otherwise they sit at zero.
  always_comb begin
    cnt_d = '0;
    idx_d = '0;
    if (run) begin
      if (cell_end) begin
        cnt_d = '0;
        idx_d = idx_q + 4'd1;
      end else begin
        cnt_d = cnt_q + 6'd1;
        idx_d = idx_q;
      end
    end
  end

  // Lets the parent register rdat_n so it lines up with the cell start.
  assign pulse_next = (cnt_d < PULSE_LEN);

  // Counter state.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/mfm_flux_gen.sv
// MFM flux pulse generator: serialises track bytes into active-low read pulses,
// produces the index pulse and substitutes gap filler on underrun.
// Optional index logic is enabled by defining MFM_FLUX_INDEX_EN.
module mfm_flux_gen
  import fdd_pkg::*;
#(
  parameter int unsigned TRACK_BYTES = 6250,
  parameter int unsigned INDEX_BYTES = 100,
  parameter logic [7:0]  FILL_BYTE   = 8'h4E
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] byte_data,
  input  logic       byte_sync,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       rdat_n,
  output logic       index_n,
  output logic       track_start,
  output logic       underrun
);

  localparam int unsigned CW = (TRACK_BYTES > 1) ? $clog2(TRACK_BYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(TRACK_BYTES - 1);

`ifdef MFM_FLUX_INDEX_EN
  localparam bit INDEX_EN = 1'b1;
`else
  localparam bit INDEX_EN = 1'b0;
`endif

  mfm_state_e state_q, state_d;

  mfm_byte_t      hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic [15:0]    shift_q, shift_d;
  logic           prev_d_q, prev_d_d;
  logic [CW-1:0]  byte_cnt_q, byte_cnt_d;
  logic           rdat_n_q, rdat_n_d;
  logic           index_n_q, index_n_d;
  logic           track_start_q, track_start_d;
  logic           underrun_q, underrun_d;

  logic      run;
  logic      load;
  logic      xfer;
  logic      in_index;
  mfm_byte_t src;
  logic      cell_end;
  logic      byte_end;
  logic      pulse_next;

  assign run  = (state_q == StRun) && enable;
  assign load = (state_q == StLoad) || (run && byte_end);
  assign xfer = byte_valid && !hold_full_q;

  mfm_cell_timer u_timer (
    .fclk       (fclk),
    .rst_n      (rst_n),
    .run        (run),
    .cell_end   (cell_end),
    .byte_end   (byte_end),
    .pulse_next (pulse_next)
  );

  // Control FSM: IDLE -> LOAD (one boundary load) -> RUN; any enable drop in RUN aborts.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable) state_d = StLoad;
      StLoad:  state_d = StRun;
      StRun:   if (!enable) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Holding register, shifter, byte counter and registered output next-state.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    prev_d_d    = prev_d_q;
    byte_cnt_d  = byte_cnt_q;
    src         = hold_full_q ? hold_q : '{sync: 1'b0, data: FILL_BYTE};

    // A byte accepted during a load cycle lands after the load empties the slot.
    if (xfer) begin
      hold_d      = '{sync: byte_sync, data: byte_data};
      hold_full_d = 1'b1;
    end else if (load) begin
      hold_full_d = 1'b0;
    end

    if (load) begin
      shift_d    = src.sync ? MFM_SYNC_A1 : mfm_encode(prev_d_q, src.data);
      prev_d_d   = src.sync ? 1'b1 : src.data[0];
      byte_cnt_d = (byte_cnt_q == LAST_BYTE) ? '0 : byte_cnt_q + CW'(1);
    end else if (run && cell_end) begin
      // Rotate rather than shift; the pattern is reloaded before wrap-around matters.
      shift_d = {shift_q[14:0], shift_q[15]};
    end else if (state_d == StIdle) begin
      prev_d_d = 1'b0;
    end

    in_index      = (32'(byte_cnt_d) < INDEX_BYTES);
    rdat_n_d      = ~((state_d == StRun) && pulse_next && shift_d[15]);
    index_n_d     = ~(INDEX_EN && (state_d != StIdle) && in_index);
    underrun_d    = load && !hold_full_q;
    track_start_d = load && (byte_cnt_q == LAST_BYTE);
  end

  // State and output registers.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      shift_q       <= '0;
      prev_d_q      <= 1'b0;
      byte_cnt_q    <= '0;
      rdat_n_q      <= 1'b1;
      index_n_q     <= 1'b1;
      track_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      shift_q       <= shift_d;
      prev_d_q      <= prev_d_d;
      byte_cnt_q    <= byte_cnt_d;
      rdat_n_q      <= rdat_n_d;
      index_n_q     <= index_n_d;
      track_start_q <= track_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign byte_ready  = ~hold_full_q;
  assign rdat_n      = rdat_n_q;
  assign index_n     = index_n_q;
  assign track_start = track_start_q;
  assign underrun    = underrun_q;

endmodule
